mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port `reset`: input, 1 bit; reset is asynchronous and active-high.
REQ-003 The block SHALL have the port `op`: input, 7 bits, opcode from the external instruction register.
REQ-004 The block SHALL have the port `funct3`: input, 3 bits, instruction bits 14:12.
REQ-005 The block SHALL have the port `funct7_5`: input, 1 bit, instruction bit 30.
REQ-006 The block SHALL have the port `Zero`: input, 1 bit, ALU zero flag.
REQ-007 The block SHALL have the output `PCWrite`: 1 bit, PC register enable.
REQ-008 The block SHALL have the output `AdrSrc`: 1 bit, memory address select (0 = PC, 1 = ALU result register).
REQ-009 The block SHALL have the output `MemWrite`: 1 bit, data memory write enable.
REQ-010 The block SHALL have the output `IRWrite`: 1 bit, instruction register and old-PC register enable.
REQ-011 The block SHALL have the output `RegWrite`: 1 bit, register file write enable.
REQ-012 The block SHALL have the output `ResultSrc`: 2 bits (00 = ALUOut, 01 = Data, 10 = ALUResult).
REQ-013 The block SHALL have the output `ALUSrcA`: 2 bits (00 = PC, 01 = OldPC, 10 = rs1 register).
REQ-014 The block SHALL have the output `ALUSrcB`: 2 bits (00 = rs2 register, 01 = ImmExt, 10 = constant 4).
REQ-015 The block SHALL have the output `ALUControl`: 3 bits (000 add, 001 sub, 010 and, 011 or, 101 slt).
REQ-016 The block SHALL have the output `ImmSrc`: 2 bits, immediate format select.
REQ-017 The block SHALL have the output `InstrDone`: 1 bit, single-cycle retire pulse.
REQ-018 The block SHALL have the output `state`: 4 bits, current state for debug.

Function
REQ-019 The block SHALL implement an 11-state Moore FSM encoded as: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10.
REQ-020 The FSM SHALL make these unconditional transitions: FETCH->DECODE; MEMREAD->MEMWB; EXECUTER->ALUWB; EXECUTEI->ALUWB; JAL->ALUWB.
REQ-021 The FSM SHALL make these transitions back to FETCH: MEMWB->FETCH; MEMWRITE->FETCH; ALUWB->FETCH; BEQ->FETCH.
REQ-022 From DECODE, the FSM SHALL transition on `op`: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other opcode -> FETCH, with no write enable asserted at any point.
REQ-023 From MEMADR, the FSM SHALL go to MEMREAD if `op` = 0000011, otherwise to MEMWRITE.
REQ-024 Each state SHALL drive the following outputs; any output not listed SHALL be 0 in that state:
- FETCH: IRWrite = 1, ALUSrcB = 10, ResultSrc = 10, PCUpdate = 1.
- DECODE: ALUSrcA = 01, ALUSrcB = 01.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01.
- MEMREAD: AdrSrc = 1.
- MEMWB: ResultSrc = 01, RegWrite = 1.
- MEMWRITE: AdrSrc = 1, MemWrite = 1.
- EXECUTER: ALUSrcA = 10, ALUOp = 10.
- EXECUTEI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10.
- ALUWB: RegWrite = 1.
- JAL: ALUSrcA = 01, ALUSrcB = 10, PCUpdate = 1.
- BEQ: ALUSrcA = 10, ALUOp = 01, Branch = 1.
REQ-025 The block SHALL drive PCWrite = PCUpdate | (Branch & Zero), combinationally, so that `Zero` is honoured in the same cycle.
REQ-026 The block SHALL decode ALUControl combinationally as follows:
- ALUOp 00 -> 000.
- ALUOp 01 -> 001.
- ALUOp 10 with `funct3` 000 -> 001 if `op`[5] & `funct7_5`, else 000.
- ALUOp 10 with `funct3` 010 -> 101; 110 -> 011; 111 -> 010; any other `funct3` -> 000.
REQ-027 The block SHALL decode ImmSrc combinationally from `op` alone: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, any other value -> 00.
REQ-028 The block SHALL assert InstrDone for exactly one cycle in MEMWB, MEMWRITE, ALUWB and BEQ, and SHALL hold it at 0 in every other state.
REQ-029 Instruction latency SHALL be: lw 5 cycles; sw 4; R-type 4; I-type 4; jal 4; beq 3; unsupported opcode 2.
REQ-030 The block SHALL never assert MemWrite and RegWrite in the same cycle, and SHALL never assert IRWrite outside FETCH.
REQ-031 The `state` output SHALL equal the current state register.

Reset
REQ-032 While `reset` = 1, the state register SHALL be forced to FETCH asynchronously, and every output SHALL show FETCH values within the same cycle.
REQ-033 A reset asserted in any state, mid-instruction, SHALL abort the instruction; after `reset` deasserts, the first rising clock edge SHALL go FETCH->DECODE.
REQ-034 During reset the block SHALL assert no MemWrite or RegWrite pulse.

Verification
REQ-035 Scenario: reset, then `op` = 0000011 -> state sequence 0,1,2,3,4,0; RegWrite = 1 only in state 4; ResultSrc = 01 in state 4; AdrSrc = 1 in state 3.
REQ-036 Scenario: `op` = 0110011, `funct3` = 000, `funct7_5` = 1 -> states 0,1,6,7,0; ALUControl = 001 in state 6; InstrDone = 1 in state 7 only.
REQ-037 Scenario: `op` = 1100011 with `Zero` = 1, then repeated with `Zero` = 0 -> PCWrite = 1 in state 10 only when `Zero` = 1; ImmSrc = 10 throughout.
REQ-038 Scenario: `op` = 0100011 -> states 0,1,2,5,0; MemWrite = 1 only in state 5; ImmSrc = 01.
REQ-039 Scenario: `op` = 1111111 (unsupported) -> states 0,1,0; no MemWrite or RegWrite asserted.
REQ-040 Scenario: `reset` pulsed asynchronously (between clock edges) while in state 3 -> state = 0 immediately, without waiting for a clock edge; MemWrite = 0 and RegWrite = 0; normal fetch resumes after deassertion.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Instruction-decode inputs and datapath control outputs of the multicycle
// controller, bundled so the datapath (master) and controller (slave) share one port.
interface mc_control_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       InstrDone;
  logic [3:0] state;

  modport master (
    output op, funct3, funct7_5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, InstrDone, state
  );

  modport slave (
    input  op, funct3, funct7_5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, InstrDone, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control unit: 11-state Moore FSM plus combinational
// ALU and immediate-format decoders.
module mc_control_fsm (
  input  logic               clk,
  input  logic               reset,
  mc_control_fsm_if.slave    bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state_r;
  state_t     next_state_s;

  logic       pc_update_s;
  logic       branch_s;
  logic       adr_src_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       instr_done_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic [2:0] alu_control_s;
  logic [1:0] imm_src_s;

  // State register; reset forces FETCH without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; unknown opcodes drop straight back to FETCH.
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH:    next_state_s = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: next_state_s = MEMADR;
          OP_R:         next_state_s = EXECUTER;
          OP_I:         next_state_s = EXECUTEI;
          OP_BEQ:       next_state_s = BEQ;
          OP_JAL:       next_state_s = JAL;
          default:      next_state_s = FETCH;
        endcase
      end
      MEMADR: begin
        if (bus.op == OP_LW) begin
          next_state_s = MEMREAD;
        end else begin
          next_state_s = MEMWRITE;
        end
      end
      MEMREAD:  next_state_s = MEMWB;
      MEMWB:    next_state_s = FETCH;
      MEMWRITE: next_state_s = FETCH;
      EXECUTER: next_state_s = ALUWB;
      EXECUTEI: next_state_s = ALUWB;
      JAL:      next_state_s = ALUWB;
      ALUWB:    next_state_s = FETCH;
      BEQ:      next_state_s = FETCH;
      default:  next_state_s = FETCH;
    endcase
  end

  // Moore outputs per state; everything not named stays 0.
  always_comb begin
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    instr_done_s = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    case (state_r)
      FETCH: begin
        ir_write_s   = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        pc_update_s  = 1'b1;
      end
      DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      MEMREAD: begin
        adr_src_s = 1'b1;
      end
      MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      MEMWRITE: begin
        adr_src_s    = 1'b1;
        mem_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      EXECUTER: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
      end
      EXECUTEI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
      end
      ALUWB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_update_s = 1'b1;
      end
      BEQ: begin
        alu_src_a_s  = 2'b10;
        alu_op_s     = 2'b01;
        branch_s     = 1'b1;
        instr_done_s = 1'b1;
      end
      default: begin
        pc_update_s = 1'b0;
      end
    endcase
  end

  // ALU operation decode; funct7 bit 5 only selects sub for register-register ops.
  always_comb begin
    alu_control_s = 3'b000;
    case (alu_op_s)
      2'b00: alu_control_s = 3'b000;
      2'b01: alu_control_s = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000: begin
            if (bus.op[5] & bus.funct7_5) begin
              alu_control_s = 3'b001;
            end else begin
              alu_control_s = 3'b000;
            end
          end
          3'b010:  alu_control_s = 3'b101;
          3'b110:  alu_control_s = 3'b011;
          3'b111:  alu_control_s = 3'b010;
          default: alu_control_s = 3'b000;
        endcase
      end
      default: alu_control_s = 3'b000;
    endcase
  end

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    imm_src_s = 2'b00;
    case (bus.op)
      OP_SW:   imm_src_s = 2'b01;
      OP_BEQ:  imm_src_s = 2'b10;
      OP_JAL:  imm_src_s = 2'b11;
      default: imm_src_s = 2'b00;
    endcase
  end

  assign bus.PCWrite    = pc_update_s | (branch_s & bus.Zero);
  assign bus.AdrSrc     = adr_src_s;
  assign bus.MemWrite   = mem_write_s;
  assign bus.IRWrite    = ir_write_s;
  assign bus.RegWrite   = reg_write_s;
  assign bus.ResultSrc  = result_src_s;
  assign bus.ALUSrcA    = alu_src_a_s;
  assign bus.ALUSrcB    = alu_src_b_s;
  assign bus.ALUControl = alu_control_s;
  assign bus.ImmSrc     = imm_src_s;
  assign bus.InstrDone  = instr_done_s;
  assign bus.state      = state_r;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction vector table, hand-written reset and
// branch sequences, then random instructions against an opcode-level model.
module tb_mc_control_fsm;

  logic clk;
  logic reset;
  mc_control_fsm_if bus ();

  mc_control_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    int          len;
    logic [19:0] st;      // state at cycle k in nibble k
    logic [2:0]  alux;    // ALUControl at cycle 2
    logic [1:0]  imm;
    int          mw_at;
    int          rw_at;
    int          done_at;
    logic [4:0]  pcw;     // PCWrite expected at cycle k in bit k
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                              input logic z, input int len, input logic [19:0] st,
                              input logic [2:0] alux, input logic [1:0] imm, input int mw_at,
                              input int rw_at, input int done_at, input logic [4:0] pcw);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.len = len; v.st = st;
    v.alux = alux; v.imm = imm; v.mw_at = mw_at; v.rw_at = rw_at;
    v.done_at = done_at; v.pcw = pcw;
    return v;
  endfunction

  // Reference: state visited at cycle k of an instruction, from its opcode class.
  function automatic int ref_len(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011: return 3;
      default:    return 2;
    endcase
  endfunction

  function automatic logic [3:0] ref_state(input logic [6:0] o, input int k);
    logic [3:0] path [5];
    path[0] = 4'd0; path[1] = 4'd1; path[2] = 4'd0; path[3] = 4'd0; path[4] = 4'd0;
    case (o)
      7'b0000011: begin path[2] = 4'd2; path[3] = 4'd3; path[4] = 4'd4; end
      7'b0100011: begin path[2] = 4'd2; path[3] = 4'd5; end
      7'b0110011: begin path[2] = 4'd6; path[3] = 4'd7; end
      7'b0010011: begin path[2] = 4'd8; path[3] = 4'd7; end
      7'b1101111: begin path[2] = 4'd9; path[3] = 4'd7; end
      7'b1100011: begin path[2] = 4'd10; end
      default:    begin path[2] = 4'd0; end
    endcase
    return path[k];
  endfunction

  // Reference: full output word for a given state and instruction fields.
  function automatic logic [16:0] exp_out(input logic [3:0] st, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7, input logic z);
    logic pcu, br, adr, mw, ir, rw, dn;
    logic [1:0] res, a, b, aop, imm;
    logic [2:0] alu;
    pcu = 1'b0; br = 1'b0; adr = 1'b0; mw = 1'b0; ir = 1'b0; rw = 1'b0; dn = 1'b0;
    res = 2'd0; a = 2'd0; b = 2'd0; aop = 2'd0;
    case (st)
      4'd0:  begin ir = 1'b1; b = 2'd2; res = 2'd2; pcu = 1'b1; end
      4'd1:  begin a = 2'd1; b = 2'd1; end
      4'd2:  begin a = 2'd2; b = 2'd1; end
      4'd3:  begin adr = 1'b1; end
      4'd4:  begin res = 2'd1; rw = 1'b1; dn = 1'b1; end
      4'd5:  begin adr = 1'b1; mw = 1'b1; dn = 1'b1; end
      4'd6:  begin a = 2'd2; aop = 2'd2; end
      4'd7:  begin rw = 1'b1; dn = 1'b1; end
      4'd8:  begin a = 2'd2; b = 2'd1; aop = 2'd2; end
      4'd9:  begin a = 2'd1; b = 2'd2; pcu = 1'b1; end
      4'd10: begin a = 2'd2; aop = 2'd1; br = 1'b1; dn = 1'b1; end
      default: begin pcu = 1'b0; end
    endcase
    if (aop == 2'd0) alu = 3'd0;
    else if (aop == 2'd1) alu = 3'd1;
    else if (f3 == 3'd0) alu = (o[5] && f7) ? 3'd1 : 3'd0;
    else if (f3 == 3'd2) alu = 3'd5;
    else if (f3 == 3'd6) alu = 3'd3;
    else if (f3 == 3'd7) alu = 3'd2;
    else alu = 3'd0;
    imm = (o == 7'b0100011) ? 2'd1 : (o == 7'b1100011) ? 2'd2 :
          (o == 7'b1101111) ? 2'd3 : 2'd0;
    return {pcu | (br & z), adr, mw, ir, rw, res, a, b, alu, imm, dn};
  endfunction

  function automatic logic [16:0] act_out();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.InstrDone};
  endfunction

  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    bus.op = o; bus.funct3 = f3; bus.funct7_5 = f7; bus.Zero = z;
  endtask

  // Run one instruction from FETCH against the model; ends on the negedge of the next FETCH.
  task automatic run_model(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    int len;
    logic [3:0] es;
    len = ref_len(o);
    drive(o, f3, f7, z);
    for (int k = 0; k < len; k++) begin
      #1;
      es = ref_state(o, k);
      chk("rnd_state", bus.state, es);
      chk("rnd_outputs", act_out(), exp_out(es, o, f3, f7, z));
      @(negedge clk);
    end
  endtask

  logic [6:0] rop;

  initial begin
    tv[0]  = mk(7'b0000011, 3'd0, 1'b0, 1'b0, 5, 20'h43210, 3'b000, 2'b00, -1,  4,  4, 5'b00001);
    tv[1]  = mk(7'b0110011, 3'd0, 1'b1, 1'b0, 4, 20'h07610, 3'b001, 2'b00, -1,  3,  3, 5'b00001);
    tv[2]  = mk(7'b0110011, 3'd0, 1'b0, 1'b0, 4, 20'h07610, 3'b000, 2'b00, -1,  3,  3, 5'b00001);
    tv[3]  = mk(7'b0110011, 3'd2, 1'b0, 1'b0, 4, 20'h07610, 3'b101, 2'b00, -1,  3,  3, 5'b00001);
    tv[4]  = mk(7'b0110011, 3'd6, 1'b0, 1'b0, 4, 20'h07610, 3'b011, 2'b00, -1,  3,  3, 5'b00001);
    tv[5]  = mk(7'b0110011, 3'd7, 1'b1, 1'b0, 4, 20'h07610, 3'b010, 2'b00, -1,  3,  3, 5'b00001);
    tv[6]  = mk(7'b0110011, 3'd1, 1'b0, 1'b0, 4, 20'h07610, 3'b000, 2'b00, -1,  3,  3, 5'b00001);
    tv[7]  = mk(7'b0010011, 3'd0, 1'b1, 1'b0, 4, 20'h07810, 3'b000, 2'b00, -1,  3,  3, 5'b00001);
    tv[8]  = mk(7'b0010011, 3'd7, 1'b0, 1'b0, 4, 20'h07810, 3'b010, 2'b00, -1,  3,  3, 5'b00001);
    tv[9]  = mk(7'b0100011, 3'd2, 1'b0, 1'b0, 4, 20'h05210, 3'b000, 2'b01,  3, -1,  3, 5'b00001);
    tv[10] = mk(7'b1101111, 3'd0, 1'b0, 1'b0, 4, 20'h07910, 3'b000, 2'b11, -1,  3,  3, 5'b00101);
    tv[11] = mk(7'b1100011, 3'd0, 1'b0, 1'b1, 3, 20'h00A10, 3'b001, 2'b10, -1, -1,  2, 5'b00101);
    tv[12] = mk(7'b1100011, 3'd0, 1'b0, 1'b0, 3, 20'h00A10, 3'b001, 2'b10, -1, -1,  2, 5'b00001);
    tv[13] = mk(7'b1111111, 3'd0, 1'b0, 1'b0, 2, 20'h00010, 3'b000, 2'b00, -1, -1, -1, 5'b00001);
    tv[14] = mk(7'b0000000, 3'd0, 1'b0, 1'b1, 2, 20'h00010, 3'b000, 2'b00, -1, -1, -1, 5'b00001);

    // Reset state, held across a clock edge.
    reset = 1'b1;
    drive(7'b0000011, 3'd0, 1'b0, 1'b0);
    #1;
    chk("reset_state", bus.state, 4'd0);
    chk("reset_outputs", act_out(), exp_out(4'd0, 7'b0000011, 3'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    chk("reset_hold_state", bus.state, 4'd0);
    chk("reset_no_writes", {bus.MemWrite, bus.RegWrite}, 2'b00);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven instructions.
    for (int i = 0; i < 15; i++) begin
      drive(tv[i].op, tv[i].f3, tv[i].f7, tv[i].z);
      for (int k = 0; k <= tv[i].len; k++) begin
        #1;
        if (k < tv[i].len) begin
          chk("tbl_state", bus.state, tv[i].st[4*k +: 4]);
          chk("tbl_imm", bus.ImmSrc, tv[i].imm);
          chk("tbl_memwrite", bus.MemWrite, (k == tv[i].mw_at) ? 1'b1 : 1'b0);
          chk("tbl_regwrite", bus.RegWrite, (k == tv[i].rw_at) ? 1'b1 : 1'b0);
          chk("tbl_done", bus.InstrDone, (k == tv[i].done_at) ? 1'b1 : 1'b0);
          chk("tbl_pcwrite", bus.PCWrite, tv[i].pcw[k]);
          chk("tbl_irwrite", bus.IRWrite, (k == 0) ? 1'b1 : 1'b0);
          if (k == 2) chk("tbl_aluctl", bus.ALUControl, tv[i].alux);
          @(negedge clk);
        end else begin
          chk("tbl_latency_fetch", bus.state, 4'd0);
        end
      end
    end

    // Branch in BEQ: Zero is honoured combinationally within the cycle.
    drive(7'b1100011, 3'd0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk); #1;
    chk("beq_state", bus.state, 4'd10);
    chk("beq_pcw_zero0", bus.PCWrite, 1'b0);
    bus.Zero = 1'b1; #1;
    chk("beq_pcw_zero1", bus.PCWrite, 1'b1);
    bus.Zero = 1'b0; #1;
    chk("beq_pcw_zero_back", bus.PCWrite, 1'b0);
    @(negedge clk); #1;
    chk("beq_back_fetch", bus.state, 4'd0);
    @(negedge clk);
    chk("beq_no_advance", bus.state, 4'd1);
    bus.op = 7'b1111111;
    @(negedge clk);

    // Asynchronous reset mid-load, between clock edges, while in MEMREAD.
    drive(7'b0000011, 3'd0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk); #2;
    chk("areset_pre_state", bus.state, 4'd3);
    reset = 1'b1; #1;
    chk("areset_state", bus.state, 4'd0);
    chk("areset_no_writes", {bus.MemWrite, bus.RegWrite}, 2'b00);
    chk("areset_outputs", act_out(), exp_out(4'd0, 7'b0000011, 3'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    chk("areset_held", bus.state, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("areset_release", bus.state, 4'd0);
    @(negedge clk); #1;
    chk("areset_resume_decode", bus.state, 4'd1);
    bus.op = 7'b1111111;
    @(negedge clk);

    // Random instructions against the opcode-level model.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: rop = 7'b0000011;
        1: rop = 7'b0100011;
        2: rop = 7'b0110011;
        3: rop = 7'b0010011;
        4: rop = 7'b1100011;
        5: rop = 7'b1101111;
        default: rop = 7'($urandom);
      endcase
      run_model(rop, 3'($urandom), 1'($urandom), 1'($urandom));
    end
    #1;
    chk("final_fetch", bus.state, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
